cart_port: RTL

- Single-master front end for SDRAM port 1 on the cartridge path.
- Downstream of data_io and the vectrex core; upstream of the SDRAM controller.
- Converts ioctl byte downloads into byte-masked 16-bit writes, and core cartridge reads into word fetches held in a one-word read cache.
- Drives the SDRAM toggle req/ack handshake, replacing ad-hoc request toggling at top level.

---
 rtl/cart_port_pkg.sv | 30 +++
 rtl/cart_port_wbuf.sv | 53 +++++
 rtl/cart_port.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cart_port_pkg.sv
// Shared types and the download address map for the cartridge SDRAM port.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package cart_port_pkg;

  typedef enum logic [1:0] {
    RESYNC  = 2'd0,
    IDLE    = 2'd1,
    WR_WAIT = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] BIOS_BASE = 2'b11;
  localparam int         BIOS_AW   = 13;
  localparam int         DL_AW     = 25;

  // Map an ioctl byte address into cartridge byte space. The BIOS image
  // (index bit0 clear) lands at 0x6000 and only its low 13 bits count.
  function automatic logic [DL_AW-1:0] dl_map(input logic index_b0,
                                              input logic [DL_AW-1:0] addr);
    logic [DL_AW-1:0] res;
    if (index_b0) begin
      res = addr;
    end else begin
      res = {{(DL_AW-BIOS_AW-2){1'b0}}, BIOS_BASE, addr[BIOS_AW-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/cart_port_wbuf.sv
// One-entry skid buffer for download bytes that arrive while the port is busy.
// Latency: a pushed byte is visible on addr/data the cycle after push.
// Backpressure: none upstream; a push into a full, non-draining buffer is dropped and flagged in overrun.
module cart_port_wbuf #(
  parameter int AW = 15
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_overrun,
  input  logic [AW-1:0] push_addr,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          overrun
);

  logic accept;
  logic drop;

  // A pop in the same cycle frees the slot, so the new byte can take it.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Hold one pending byte; refill on accept, empty on a bare pop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      addr <= push_addr;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the clearing cycle still wins.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/cart_port.sv
// SDRAM port-1 front end: ioctl byte writes and cached cartridge word reads over a toggle req/ack.
// Latency: write issued the cycle after dl_wr; read miss issued next cycle, valid the cycle after ack.
// Backpressure: one-byte write buffer, further bytes dropped (dl_overrun); reads stall while downloading or busy.
module cart_port
  import cart_port_pkg::*;
#(
  parameter int ADDR_W        = 15,
  parameter int RESYNC_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic [7:0]        dl_index,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cart_rd,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_do,
  output logic              cart_valid,
  output logic              dl_busy,
  output logic              dl_overrun,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [23:0]       sd_a,
  output logic              sd_we,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q
);

  localparam int WA_W  = ADDR_W - 1;
  localparam int CNT_W = $clog2(RESYNC_CYCLES + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   resync_cnt;
  logic               dl_active_q;
  logic               dl_rise;
  logic [WA_W-1:0]    tag;
  logic               tag_valid;
  logic [15:0]        word;
  logic               rd_discard;
  logic [DL_AW-1:0]   dl_mapped;
  logic [ADDR_W-1:0]  dl_byte;
  logic               ack_match;
  logic               rd_miss;
  logic               issue_buf;
  logic               issue_dl;
  logic               issue_rd;
  logic               adopt;
  logic               wr_done;
  logic               rd_done;
  logic               wb_push;
  logic               wb_full;
  logic               wb_overrun;
  logic [ADDR_W-1:0]  wb_addr;
  logic [7:0]         wb_data;
  logic [ADDR_W-1:0]  wr_byte;
  logic [7:0]         wr_data;
  logic               unused_dl;

  assign dl_mapped = dl_map(dl_index[0], dl_addr);
  assign dl_byte   = dl_mapped[ADDR_W-1:0];
  assign unused_dl = ^{dl_index[7:1], dl_mapped[DL_AW-1:ADDR_W]};

  assign dl_rise   = dl_active & ~dl_active_q;
  assign ack_match = (sd_ack == sd_req);
  assign rd_miss   = ~dl_active & cart_rd &
                     (~tag_valid | (tag != cart_addr[ADDR_W-1:1]));

  // Bytes that cannot be issued directly go to the buffer; when the buffer
  // drains this cycle it can take the new byte at the same time.
  assign wb_push = dl_wr & ((state != IDLE) | issue_buf);
  assign wr_byte = issue_buf ? wb_addr : dl_byte;
  assign wr_data = issue_buf ? wb_data : dl_data;

  assign cart_do    = cart_addr[0] ? word[15:8] : word[7:0];
  assign cart_valid = tag_valid & (tag == cart_addr[ADDR_W-1:1]) & ~dl_active;
  assign dl_busy    = (state == WR_WAIT) | wb_full;
  assign dl_overrun = wb_overrun;

  cart_port_wbuf #(
    .AW (ADDR_W)
  ) u_wbuf (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .push        (wb_push),
    .pop         (issue_buf),
    .clr_overrun (dl_rise),
    .push_addr   (dl_byte),
    .push_data   (dl_data),
    .full        (wb_full),
    .addr        (wb_addr),
    .data        (wb_data),
    .overrun     (wb_overrun)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and one-cycle issue strobes; buffered write beats new byte beats read miss.
  always_comb begin
    state_nxt = state;
    issue_buf = 1'b0;
    issue_dl  = 1'b0;
    issue_rd  = 1'b0;
    adopt     = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      RESYNC: begin
        if (resync_cnt == CNT_W'(RESYNC_CYCLES - 1)) begin
          adopt     = 1'b1;
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (wb_full) begin
          issue_buf = 1'b1;
          state_nxt = WR_WAIT;
        end else if (dl_wr) begin
          issue_dl  = 1'b1;
          state_nxt = WR_WAIT;
        end else if (rd_miss) begin
          issue_rd  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (ack_match) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (ack_match) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  // SDRAM request side: resync counter, request toggle and command fields.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      resync_cnt <= '0;
      sd_req     <= 1'b0;
      sd_a       <= '0;
      sd_we      <= 1'b0;
      sd_ds      <= '0;
      sd_d       <= '0;
    end else begin
      if (state == RESYNC) begin
        resync_cnt <= resync_cnt + CNT_W'(1);
      end
      if (adopt) begin
        sd_req <= sd_ack;
      end
      if (issue_buf | issue_dl) begin
        sd_a   <= 24'(wr_byte[ADDR_W-1:1]);
        sd_ds  <= {wr_byte[0], ~wr_byte[0]};
        sd_d   <= {wr_data, wr_data};
        sd_we  <= 1'b1;
        sd_req <= ~sd_req;
      end else if (issue_rd) begin
        sd_a   <= 24'(cart_addr[ADDR_W-1:1]);
        sd_ds  <= 2'b11;
        sd_we  <= 1'b0;
        sd_req <= ~sd_req;
      end
      if (wr_done) begin
        sd_we <= 1'b0;
      end
    end
  end

  // Read cache: tag/word fill, invalidation on download start or overlapping write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      tag         <= '0;
      tag_valid   <= 1'b0;
      word        <= '0;
      rd_discard  <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (issue_rd) begin
        tag        <= cart_addr[ADDR_W-1:1];
        tag_valid  <= 1'b0;
        rd_discard <= 1'b0;
      end else if (rd_done) begin
        word      <= sd_q;
        tag_valid <= ~(rd_discard | dl_rise);
      end else if (dl_rise) begin
        tag_valid <= 1'b0;
      end else if ((issue_buf | issue_dl) && (wr_byte[ADDR_W-1:1] == tag)) begin
        tag_valid <= 1'b0;
      end
      // A download starting under an outstanding read poisons its data.
      if (dl_rise && (state == RD_WAIT)) begin
        rd_discard <= 1'b1;
      end
    end
  end

endmodule
